// File: rtl/bcd_count4.sv
// Four-digit BCD event counter with a switch-selected rate prescaler, feeding the sevenseg digits.
// Optional define BCD_COUNT4_DOWN_EN adds a dir input for up/down counting.
module bcd_count4 #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    input  logic       hold,
`ifdef BCD_COUNT4_DOWN_EN
    input  logic       dir,
`endif
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       wrap,
    output logic       tick
);

    // Terminal prescaler count (DIV-1) for each rate setting; DIV is clamped to >= 1.
    function automatic logic [31:0] div_m1(input logic [2:0] s);
        int unsigned rate;
        int unsigned d;
        case (s)
            3'd1:    rate = 1;
            3'd2:    rate = 2;
            3'd3:    rate = 5;
            3'd4:    rate = 10;
            3'd5:    rate = 100;
            3'd6:    rate = 1000;
            default: rate = CLK_HZ;
        endcase
        d = CLK_HZ / rate;
        if (d == 0) d = 1;
        return 32'(d - 1);
    endfunction

    logic [2:0]       sw_q;
    logic [31:0]      cnt;
    logic [31:0]      cnt_end;
    logic [3:0][3:0]  dig;
    logic [3:0][3:0]  dig_nxt;
    logic             carry_out;
    logic             down;
    logic             apply;

`ifdef BCD_COUNT4_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    assign cnt_end = div_m1(sw_q);
    assign apply   = tick & ~hold;

    // Ripple the carry/borrow through the digits; a digit moves only while every lower one rolled.
    always_comb begin
        logic c;
        dig_nxt = dig;
        c       = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c) begin
                if (down) begin
                    if (dig[i] == 4'd0) begin
                        dig_nxt[i] = 4'd9;
                    end else begin
                        dig_nxt[i] = dig[i] - 4'd1;
                        c          = 1'b0;
                    end
                end else begin
                    if (dig[i] >= 4'd9) begin
                        dig_nxt[i] = 4'd0;
                    end else begin
                        dig_nxt[i] = dig[i] + 4'd1;
                        c          = 1'b0;
                    end
                end
            end
        end
        carry_out = c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig  <= '0;
            wrap <= 1'b0;
            tick <= 1'b0;
            cnt  <= '0;
            sw_q <= sw;
        end else begin
            if (apply) begin
                dig  <= dig_nxt;
                wrap <= carry_out;
            end else begin
                wrap <= 1'b0;
            end

            if (sw != sw_q) begin
                sw_q <= sw;
                cnt  <= '0;
                tick <= 1'b0;
            end else if (hold) begin
                tick <= 1'b0;
            end else if (sw_q == 3'd0) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (cnt >= cnt_end) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 32'd1;
                tick <= 1'b0;
            end
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign digit3 = dig[3];

endmodule

// File: tb/tb_bcd_count4.sv
// Self-checking bench for bcd_count4: integer-valued reference model plus directed and random scenarios.
module tb_bcd_count4;

    localparam int unsigned CLK_HZ = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] sw = 3'd0;
    logic       hold = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic       wrap, tick;

    always #5 clk = ~clk;

    bcd_count4 #(.CLK_HZ(CLK_HZ)) dut (
        .clk    (clk),
        .reset  (reset),
        .sw     (sw),
        .hold   (hold),
`ifdef BCD_COUNT4_DOWN_EN
        .dir    (dir),
`endif
        .digit0 (digit0),
        .digit1 (digit1),
        .digit2 (digit2),
        .digit3 (digit3),
        .wrap   (wrap),
        .tick   (tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the count is a plain integer 0..9999.
    int         m_val = 0;
    int         m_psc = 0;
    logic [2:0] m_sw = 3'd0;
    logic       m_tick = 1'b0;
    logic       m_wrap = 1'b0;

    function automatic int div_of(input logic [2:0] s);
        int rate;
        int d;
        case (s)
            3'd1: rate = 1;
            3'd2: rate = 2;
            3'd3: rate = 5;
            3'd4: rate = 10;
            3'd5: rate = 100;
            3'd6: rate = 1000;
            default: rate = CLK_HZ;
        endcase
        d = CLK_HZ / rate;
        return (d < 1) ? 1 : d;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_val = 0; m_psc = 0; m_tick = 1'b0; m_wrap = 1'b0; m_sw = sw;
        end else begin
            if (m_tick && !hold) begin
                if (dir) begin
                    m_wrap = (m_val == 0);
                    m_val  = (m_val + 9999) % 10000;
                end else begin
                    m_wrap = (m_val == 9999);
                    m_val  = (m_val + 1) % 10000;
                end
            end else begin
                m_wrap = 1'b0;
            end
            if (sw != m_sw) begin
                m_sw = sw; m_psc = 0; m_tick = 1'b0;
            end else if (hold) begin
                m_tick = 1'b0;
            end else if (m_sw == 3'd0) begin
                m_psc = 0; m_tick = 1'b0;
            end else if (m_psc >= div_of(m_sw) - 1) begin
                m_psc = 0; m_tick = 1'b1;
            end else begin
                m_psc = m_psc + 1; m_tick = 1'b0;
            end
        end
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    logic [15:0] dut_bcd;
    logic [17:0] dut_obs;
    logic [17:0] mdl_obs;
    assign dut_bcd = {digit3, digit2, digit1, digit0};
    assign dut_obs = {dut_bcd, wrap, tick};
    always_comb mdl_obs = {to_bcd(m_val), m_wrap, m_tick};

    task automatic do_reset(input logic [2:0] s, input int n);
        @(negedge clk);
        reset = 1'b1; sw = s; hold = 1'b0; dir = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'd0, 2);
        n_cmp++;
        if (dut_obs !== 18'h0) begin
            n_bad++; $display("FAIL reset_state: got %h want %h", dut_obs, 18'h0);
        end
        n_cmp++;
        if (dut_obs !== mdl_obs) begin
            n_bad++; $display("FAIL reset_model: got %h want %h", dut_obs, mdl_obs);
        end
    endtask

    task automatic test_fast_count();
        sw = 3'd7;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL fast_count cyc %0d: got %h want %h", i, dut_obs, mdl_obs);
            end
            n_cmp++;
            if (wrap !== 1'b0 || digit0 > 4'd9 || digit1 > 4'd9) begin
                n_bad++; $display("FAIL fast_range cyc %0d: got wrap=%b bcd=%h want wrap=0 digits<=9", i, wrap, dut_bcd);
            end
        end
        n_cmp++;
        if (dut_bcd !== 16'h0023) begin
            n_bad++; $display("FAIL fast_final: got %h want 0023", dut_bcd);
        end
    endtask

    task automatic test_carry();
        bit reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL carry_run: got %h want %h", dut_obs, mdl_obs);
            end
            if (m_val == 999) reached = 1;
        end
        n_cmp++;
        if (!reached || dut_bcd !== 16'h0999) begin
            n_bad++; $display("FAIL carry_0999: got %h want 0999", dut_bcd);
        end
        @(negedge clk);
        n_cmp++;
        if (dut_bcd !== 16'h1000 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL carry_1000: got %h wrap=%b want 1000 wrap=0", dut_bcd, wrap);
        end
        reached = 0;
        for (int i = 0; i < 10000 && !reached; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL carry_run2: got %h want %h", dut_obs, mdl_obs);
            end
            if (m_val == 9999) reached = 1;
        end
        @(negedge clk);
        n_cmp++;
        if (!reached || dut_bcd !== 16'h0000 || wrap !== 1'b1) begin
            n_bad++; $display("FAIL wrap_edge: got %h wrap=%b want 0000 wrap=1", dut_bcd, wrap);
        end
        @(negedge clk);
        n_cmp++;
        if (dut_bcd !== 16'h0001 || wrap !== 1'b0) begin
            n_bad++; $display("FAIL wrap_after: got %h wrap=%b want 0001 wrap=0", dut_bcd, wrap);
        end
    endtask

    task automatic test_slow_rate();
        int first = -1;
        do_reset(3'd1, 2);
        for (int k = 1; k <= 2001; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL slow_run k=%0d: got %h want %h", k, dut_obs, mdl_obs);
            end
            if (tick === 1'b1 && first < 0) first = k;
            if (k == 1001 || k == 2001) begin
                n_cmp++;
                if (dut_bcd !== ((k == 1001) ? 16'h0001 : 16'h0002)) begin
                    n_bad++; $display("FAIL slow_digits k=%0d: got %h want %0d", k, dut_bcd, (k == 1001) ? 1 : 2);
                end
            end
        end
        n_cmp++;
        if (first != 1000) begin
            n_bad++; $display("FAIL slow_first_tick: got %0d want 1000", first);
        end
    endtask

    task automatic test_sw_change();
        int first = -1;
        do_reset(3'd1, 2);
        repeat (600) @(negedge clk);
        sw = 3'd4;
        for (int k = 1; k <= 300 && first < 0; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL swchg_run k=%0d: got %h want %h", k, dut_obs, mdl_obs);
            end
            if (tick === 1'b1) first = k;
        end
        n_cmp++;
        if (first != 101) begin
            n_bad++; $display("FAIL swchg_next_tick: got %0d edges want 101", first);
        end
    endtask

    task automatic test_hold();
        bit reached = 0;
        do_reset(3'd0, 2);
        sw = 3'd7;
        for (int i = 0; i < 100 && !reached; i++) begin
            @(negedge clk);
            if (m_val == 42) reached = 1;
        end
        hold = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_cmp++;
            if (!reached || dut_bcd !== 16'h0042 || tick !== 1'b0 || dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL hold_frozen cyc %0d: got %h tick=%b want 0042 tick=0", i, dut_bcd, tick);
            end
        end
        hold = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dut_bcd !== 16'h0042) begin
            n_bad++; $display("FAIL hold_release1: got %h want 0042", dut_bcd);
        end
        @(negedge clk);
        n_cmp++;
        if (dut_bcd !== 16'h0043) begin
            n_bad++; $display("FAIL hold_release2: got %h want 0043", dut_bcd);
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 2; t++) begin
            int target = (t == 0) ? 567 : 999;
            bit reached = 0;
            do_reset(3'd0, 2);
            sw = 3'd7;
            for (int i = 0; i < 1200 && !reached; i++) begin
                @(negedge clk);
                if (m_val == target) reached = 1;
            end
            reset = 1'b1;
            @(negedge clk);
            n_cmp++;
            if (!reached || dut_bcd !== 16'h0000 || wrap !== 1'b0 || tick !== 1'b0) begin
                n_bad++; $display("FAIL reset_mid %0d: got %h wrap=%b tick=%b want 0000 0 0", target, dut_bcd, wrap, tick);
            end
            reset = 1'b0;
        end
    endtask

    task automatic test_random();
        do_reset(3'd7, 2);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) sw = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 99) < 2) sw = 3'($urandom_range(5, 7));
            hold  = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 299) == 0);
`ifdef BCD_COUNT4_DOWN_EN
            if ($urandom_range(0, 49) == 0) dir = ~dir;
`endif
            @(negedge clk);
            n_cmp++;
            if (dut_obs !== mdl_obs) begin
                n_bad++; $display("FAIL random cyc %0d: got %h want %h", i, dut_obs, mdl_obs);
            end
        end
        reset = 1'b0; hold = 1'b0; dir = 1'b0;
    endtask

`ifdef BCD_COUNT4_DOWN_EN
    task automatic test_down();
        logic [16:0] want [6] = '{17'h00010, 17'h00000, 17'h19999, 17'h09998, 17'h09999, 17'h10000};
        bit reached = 0;
        do_reset(3'd0, 2);
        sw = 3'd7;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge clk);
            if (m_val == 2) reached = 1;
        end
        dir = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) dir = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (!reached || {wrap, dut_bcd} !== (i == 0 ? 17'h00001 : want[i])) begin
                n_bad++; $display("FAIL down step %0d: got wrap=%b %h want %h", i, wrap, dut_bcd, (i == 0 ? 17'h00001 : want[i]));
            end
        end
        dir = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fast_count();
        test_carry();
        test_slow_rate();
        test_sw_change();
        test_hold();
        test_reset_mid();
`ifdef BCD_COUNT4_DOWN_EN
        test_down();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_count4.md
Name: bcd_count4

Overview:
- Synchronous 4-digit decimal (BCD) event counter with a switch-selected rate prescaler.
- Sits directly upstream of the sevenseg display multiplexer and drives its four digit inputs.
- Replaces the combinational digit cascade in the top level with a fully clocked carry chain, so no digit ever shows a value above 9.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz; the bench overrides it with 1000.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sw  in  3  rate select.
- hold  in  1  freeze: while high, ticks are ignored and the prescaler is held.
- digit0  out  4  BCD units, to sevenseg digit0.
- digit1  out  4  BCD tens.
- digit2  out  4  BCD hundreds.
- digit3  out  4  BCD thousands.
- wrap  out  1  one-cycle pulse when the count rolls over.
- tick  out  1  one-cycle prescaler tick; for debug and LED use.

Behaviour:
- Reset: sampled on posedge clk only. It has priority over every other input.
  - All outputs go to 0: digits 0000, wrap 0, tick 0.
  - Prescaler count goes to 0.
  - The registered copy of sw is loaded with the current sw.
- Rate table (sw -> increments per second):
  - 0 -> stopped
  - 1 -> 1
  - 2 -> 2
  - 3 -> 5
  - 4 -> 10
  - 5 -> 100
  - 6 -> 1000
  - 7 -> every clock
- Divisor: DIV = CLK_HZ / rate, using integer division and clamped to a minimum of 1. The prescaler counter is 32 bits wide.
- Prescaler operation:
  - It counts 0 .. DIV-1.
  - tick is registered; it goes high for the one cycle after the count reaches DIV-1, and the count returns to 0 on that same edge.
  - sw=7: tick is high on every cycle.
  - sw=0: count is held at 0 and tick stays 0.
- sw change: the registered sw differs from the input sw.
  - The prescaler count is cleared to 0 on that edge and no tick is generated.
  - The new rate takes effect from the next cycle.
  - The digits are unaffected.
- hold=1: the prescaler count is frozen, tick is forced to 0, and the digits are frozen. Releasing hold resumes counting from the frozen prescaler value.
- Increment: on the cycle where the registered tick=1 and hold=0, the digits update on that edge, one cycle after the tick asserts.
  - digit0 increments. When digit0 is 9 it becomes 0 and generates a carry.
  - Each carry increments the next digit under the same rule. A digit only changes when every lower digit is 9.
- Wrap: 9999 -> 0000 in a single edge; wrap pulses high for exactly that one cycle. Otherwise wrap is 0.
- Latency: from the prescaler reaching DIV-1 to the digit change is 2 edges (tick register, then digit register).
- Invariant: each digit is in 0..9 at all times, including immediately after reset.
- Reset mid-carry: for example, reset asserted on the edge where 0999 would become 1000 gives 0000 with no wrap pulse.
- Simultaneous reset and tick: reset wins.
- Simultaneous tick and hold: hold wins and the tick is dropped.

Optional Feature:
- Macro: BCD_COUNT4_DOWN_EN.
- Defined:
  - Adds input port dir (1 bit), placed after hold. dir=1 decrements and dir=0 increments.
  - Decrement borrow rule: a digit at 0 becomes 9 and borrows from the next digit.
  - 0000 -> 9999 with a one-cycle wrap pulse.
  - A change of dir takes effect on the next applied tick; it has no effect on the prescaler.
- Not defined: no dir port exists and the block is up-count only.

Test Plan:
- CLK_HZ=1000, reset high for 2 cycles, then sw=7 for 25 cycles -> digits reach 0023 (2-cycle latency). wrap never asserts and all digits stay <=9.
- Preload by counting to 0999 with sw=7, then allow one more tick -> a single edge gives 1000. Continue to 9999 -> next edge gives 0000 with wrap=1 for exactly 1 cycle.
- sw=1 (DIV=1000) from reset -> tick is first seen high 1000 edges after reset release. Digits read 0001 after 1001 edges and 0002 after 2001 edges.
- sw changed from 1 to 4 when the prescaler count is 600 -> no tick on the change edge. The next tick arrives 100 cycles later, not 400.
- hold=1 for 50 cycles at sw=7 with digits 0042 -> digits stay 0042 and tick stays 0. After release, 0043 appears 2 edges later. Reset pulsed at count 0567 -> 0000 on the next edge with wrap=0.
- BCD_COUNT4_DOWN_EN defined: dir=1, sw=7, start 0002 -> 0001, 0000, 9999 (wrap=1), 9998. dir=0 -> counts back up to 9999.
